// File: rtl/cp0_pkg.sv
// Shared definitions for the nested coprocessor-0 block: register indices,
// exception codes, Status/Cause bit positions, reset constants and the
// saved-context record.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_BP  = 5'd9,
    EXC_TR  = 5'd13
  } exc_code_e;

  // Status bit positions
  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_SYS = 1;
  localparam int unsigned ST_BP  = 2;
  localparam int unsigned ST_TR  = 3;
  localparam int unsigned ST_IM  = 8;
  localparam int unsigned ST_TM  = 15;

  // Cause bit positions
  localparam int unsigned CA_EXC = 2;
  localparam int unsigned CA_IP  = 8;
  localparam int unsigned CA_OVF = 29;
  localparam int unsigned CA_TI  = 30;

  localparam logic [31:0] STATUS_RST  = 32'h0000_000F;
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] status;
    logic [31:0] epc;
  } cp0_ctx_t;

  // Per-code enable bit in Status; unknown codes are never enabled.
  function automatic logic cause_enabled(input logic [31:0] st, input logic [4:0] code);
    case (exc_code_e'(code))
      EXC_SYS: return st[ST_SYS];
      EXC_BP:  return st[ST_BP];
      EXC_TR:  return st[ST_TR];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cp0_nested_if.sv
// CPU <-> CP0 signal bundle. The CPU side is the master; cp0_nested is the slave.
interface cp0_nested_if #(parameter int unsigned N_IRQ = 6);
  logic              mfc0;
  logic              mtc0;
  logic [4:0]        rd;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [31:0]       pc;
  logic              exception;
  logic [4:0]        cause;
  logic              eret;
  logic [N_IRQ-1:0]  irq;
  logic              exc_take;
  logic [31:0]       status;
  logic [31:0]       exc_addr;
  logic [3:0]        depth;

  modport master (
    output mfc0, mtc0, rd, wdata, pc, exception, cause, eret, irq,
    input  rdata, exc_take, status, exc_addr, depth
  );

  modport slave (
    input  mfc0, mtc0, rd, wdata, pc, exception, cause, eret, irq,
    output rdata, exc_take, status, exc_addr, depth
  );
endinterface

// File: rtl/cp0_ctx_stack.sv
// LIFO of saved {status, epc} contexts. Push when full and pop when empty
// are ignored; top reads 0 when empty.
module cp0_ctx_stack
  import cp0_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  cp0_ctx_t push_ctx,
  output cp0_ctx_t top,
  output logic [3:0] depth,
  output logic     full,
  output logic     empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cp0_ctx_t   mem [DEPTH];
  logic [3:0] cnt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign full   = (cnt == 4'(DEPTH));
  assign empty  = (cnt == 4'd0);
  assign depth  = cnt;
  assign wr_idx = AW'(cnt);
  assign rd_idx = AW'(cnt - 4'd1);

  // Top-of-stack view
  always_comb begin
    top = '0;
    if (!empty) top = mem[rd_idx];
  end

  // Storage and occupancy; push takes precedence if both are asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_ctx;
      cnt         <= cnt + 4'd1;
    end else if (pop && !empty) begin
      cnt <= cnt - 4'd1;
    end
  end
endmodule

// File: rtl/cp0_nested.sv
// Coprocessor-0 with a hardware context stack for nested exceptions and
// interrupts. Define CP0_TIMER_EN to build the Count/Compare timer.
module cp0_nested
  import cp0_pkg::*;
#(
  parameter int unsigned NEST_DEPTH = 4,
  parameter int unsigned N_IRQ      = 6
) (
  input  logic clk,
  input  logic rst_n,
  cp0_nested_if.slave bus
);
  logic [31:0]      status_q;
  logic [31:0]      epc_q;
  logic [4:0]       code_q;
  logic             ovf_q;
  logic             ti_q;
  logic [N_IRQ-1:0] irq_s1, irq_s2;
  logic             timer_hit;
  logic             exc_ok, int_ok, req, accept, pop;
  logic [31:0]      cause_rd;
  cp0_ctx_t         top_ctx;
  logic             full, empty;

  assign exc_ok = bus.exception & status_q[ST_IE] & cause_enabled(status_q, bus.cause);
  assign int_ok = !bus.exception & status_q[ST_IE] &
                  ((|(irq_s2 & status_q[ST_IM +: N_IRQ])) | timer_hit);
  assign req    = exc_ok | int_ok;
  // mtc0 outranks acceptance, so a write cycle never reports a take
  assign accept = req & !full & !bus.mtc0;
  assign pop    = bus.eret & !empty & !bus.mtc0 & !accept;

  assign bus.exc_take = accept;
  assign bus.status   = status_q;
  assign bus.exc_addr = epc_q;

  cp0_ctx_stack #(.DEPTH(NEST_DEPTH)) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .pop      (pop),
    .push_ctx ('{status: status_q, epc: epc_q}),
    .top      (top_ctx),
    .depth    (bus.depth),
    .full     (full),
    .empty    (empty)
  );

  // Two-flop synchroniser for the asynchronous interrupt lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1 <= '0;
      irq_s2 <= '0;
    end else begin
      irq_s1 <= bus.irq;
      irq_s2 <= irq_s1;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, compare_q, count_next;
  logic        wr_count, wr_compare;

  assign wr_count   = bus.mtc0 && (bus.rd == REG_COUNT);
  assign wr_compare = bus.mtc0 && (bus.rd == REG_COMPARE);
  assign timer_hit  = ti_q & status_q[ST_TM];

  // Next Count: a software write replaces the increment
  always_comb begin
    count_next = count_q + 32'd1;
    if (wr_count) count_next = bus.wdata;
  end

  // Count/Compare and the timer-pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= COMPARE_RST;
      ti_q      <= 1'b0;
    end else begin
      count_q <= count_next;
      if (wr_compare) begin
        compare_q <= bus.wdata;
        ti_q      <= 1'b0;
      end else if (count_next == compare_q) begin
        ti_q <= 1'b1;
      end
    end
  end
`else
  assign ti_q      = 1'b0;
  assign timer_hit = 1'b0;
`endif

  // Status/Cause/EPC update: mtc0, then accept, then eret
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= STATUS_RST;
      epc_q    <= '0;
      code_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (bus.mtc0) begin
        case (bus.rd)
          REG_STATUS: status_q <= bus.wdata;
          REG_CAUSE:  ovf_q    <= bus.wdata[CA_OVF];
          REG_EPC:    epc_q    <= bus.wdata;
          default:    ;
        endcase
      end else if (accept) begin
        status_q        <= status_q;
        status_q[ST_IE] <= 1'b0;
        code_q          <= bus.exception ? bus.cause : EXC_INT;
        epc_q           <= bus.exception ? (bus.pc - 32'd4) : bus.pc;
      end else if (pop) begin
        status_q <= top_ctx.status;
        epc_q    <= top_ctx.epc;
      end
      if (!bus.mtc0 && req && full) ovf_q <= 1'b1;
    end
  end

  // Cause as seen by software
  always_comb begin
    cause_rd                  = '0;
    cause_rd[CA_EXC +: 5]     = code_q;
    cause_rd[CA_IP +: N_IRQ]  = irq_s2;
    cause_rd[CA_OVF]          = ovf_q;
    cause_rd[CA_TI]           = ti_q;
  end

  // mfc0 read mux
  always_comb begin
    bus.rdata = '0;
    if (bus.mfc0) begin
      case (bus.rd)
        REG_STATUS:  bus.rdata = status_q;
        REG_CAUSE:   bus.rdata = cause_rd;
        REG_EPC:     bus.rdata = epc_q;
`ifdef CP0_TIMER_EN
        REG_COUNT:   bus.rdata = count_q;
        REG_COMPARE: bus.rdata = compare_q;
`endif
        default:     bus.rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_cp0_nested.sv
// Directed table-driven bench for cp0_nested plus hand sequences for the
// interrupt synchroniser, timer, and reset inside a handler.
module tb_cp0_nested;
  localparam int unsigned NEST_DEPTH = 4;
  localparam int unsigned N_IRQ      = 6;
`ifdef CP0_TIMER_EN
  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CMP_RST = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cp0_nested_if #(.N_IRQ(N_IRQ)) bus ();

  cp0_nested #(.NEST_DEPTH(NEST_DEPTH), .N_IRQ(N_IRQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        mfc0, mtc0;
    logic [4:0]  rd;
    logic [31:0] wdata, pc;
    logic        exc;
    logic [4:0]  cause;
    logic        eret;
    logic        take;
    logic [31:0] rdata, st, epc;
    logic [3:0]  dep;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic f, input logic t, input logic [4:0] rd,
                              input logic [31:0] wd, input logic [31:0] pc,
                              input logic ex, input logic [4:0] ca, input logic er,
                              input logic tk, input logic [31:0] rdv,
                              input logic [31:0] st, input logic [31:0] epc,
                              input logic [3:0] dp);
    vec_t v;
    v.mfc0 = f; v.mtc0 = t; v.rd = rd; v.wdata = wd; v.pc = pc;
    v.exc = ex; v.cause = ca; v.eret = er; v.take = tk; v.rdata = rdv;
    v.st = st; v.epc = epc; v.dep = dp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.mfc0 = 0; bus.mtc0 = 0; bus.rd = '0; bus.wdata = '0;
    bus.exception = 0; bus.cause = '0; bus.eret = 0;
  endtask

  task automatic do_mtc0(input logic [4:0] rd, input logic [31:0] wd);
    @(negedge clk);
    bus.mtc0 = 1; bus.rd = rd; bus.wdata = wd;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic read_chk(input string name, input logic [4:0] rd, input logic [31:0] exp);
    bus.mfc0 = 1; bus.rd = rd;
    #1;
    check(name, bus.rdata, exp);
    bus.mfc0 = 0; bus.rd = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    bus.mfc0 = v.mfc0; bus.mtc0 = v.mtc0; bus.rd = v.rd; bus.wdata = v.wdata;
    bus.pc = v.pc; bus.exception = v.exc; bus.cause = v.cause; bus.eret = v.eret;
    #1;
    check($sformatf("row%0d exc_take", idx), 32'(bus.exc_take), 32'(v.take));
    check($sformatf("row%0d rdata", idx), bus.rdata, v.rdata);
    @(posedge clk); #1;
    idle();
    check($sformatf("row%0d status", idx), bus.status, v.st);
    check($sformatf("row%0d exc_addr", idx), bus.exc_addr, v.epc);
    check($sformatf("row%0d depth", idx), 32'(bus.depth), 32'(v.dep));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.pc = '0;
    bus.irq = '0;

    //      mfc0 mtc0 rd  wdata          pc        ex ca   er  take rdata          status         epc       dep
    tv.push_back(mk(1, 0, 12, 0,            0,        0, 0,   0,  0, 32'hF,         32'hF,         0,        0));
    tv.push_back(mk(1, 0, 13, 0,            0,        0, 0,   0,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(1, 0, 14, 0,            0,        0, 0,   0,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(1, 0, 11, 0,            0,        0, 0,   0,  0, CMP_RST,       32'hF,         0,        0));
    tv.push_back(mk(1, 0, 5,  0,            0,        0, 0,   0,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(0, 0, 0,  0,            32'h100,  1, 8,   0,  1, 32'h0,         32'hE,         32'hFC,   1));
    tv.push_back(mk(1, 0, 13, 0,            0,        0, 0,   0,  0, 32'h20,        32'hE,         32'hFC,   1));
    tv.push_back(mk(0, 0, 0,  0,            0,        0, 0,   1,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(0, 0, 0,  0,            0,        0, 0,   1,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(0, 0, 0,  0,            32'h200,  1, 9,   0,  1, 32'h0,         32'hE,         32'h1FC,  1));
    tv.push_back(mk(0, 1, 12, 32'hF,        0,        0, 0,   0,  0, 32'h0,         32'hF,         32'h1FC,  1));
    tv.push_back(mk(0, 0, 0,  0,            32'h300,  1, 13,  0,  1, 32'h0,         32'hE,         32'h2FC,  2));
    tv.push_back(mk(0, 1, 12, 32'hF,        0,        0, 0,   0,  0, 32'h0,         32'hF,         32'h2FC,  2));
    tv.push_back(mk(0, 0, 0,  0,            32'h400,  1, 8,   0,  1, 32'h0,         32'hE,         32'h3FC,  3));
    tv.push_back(mk(0, 1, 12, 32'hF,        0,        0, 0,   0,  0, 32'h0,         32'hF,         32'h3FC,  3));
    tv.push_back(mk(0, 0, 0,  0,            32'h500,  1, 8,   0,  1, 32'h0,         32'hE,         32'h4FC,  4));
    tv.push_back(mk(0, 1, 12, 32'hF,        0,        0, 0,   0,  0, 32'h0,         32'hF,         32'h4FC,  4));
    tv.push_back(mk(0, 0, 0,  0,            32'h600,  1, 8,   0,  0, 32'h0,         32'hF,         32'h4FC,  4));
    tv.push_back(mk(1, 0, 13, 0,            0,        0, 0,   0,  0, 32'h2000_0020, 32'hF,         32'h4FC,  4));
    tv.push_back(mk(0, 0, 0,  0,            0,        0, 0,   1,  0, 32'h0,         32'hF,         32'h3FC,  3));
    tv.push_back(mk(0, 0, 0,  0,            0,        0, 0,   1,  0, 32'h0,         32'hF,         32'h2FC,  2));
    tv.push_back(mk(0, 0, 0,  0,            0,        0, 0,   1,  0, 32'h0,         32'hF,         32'h1FC,  1));
    tv.push_back(mk(0, 0, 0,  0,            0,        0, 0,   1,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(0, 1, 13, 0,            0,        0, 0,   0,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(1, 0, 13, 0,            0,        0, 0,   0,  0, 32'h20,        32'hF,         0,        0));
    tv.push_back(mk(0, 1, 12, 32'h12345607, 32'h700,  1, 8,   0,  0, 32'h0,         32'h12345607,  0,        0));
    tv.push_back(mk(0, 1, 12, 32'hF,        0,        0, 0,   0,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(1, 1, 12, 32'h7,        0,        0, 0,   0,  0, 32'hF,         32'h7,         0,        0));
    tv.push_back(mk(0, 1, 12, 32'hF,        0,        0, 0,   0,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(0, 0, 0,  0,            32'h800,  1, 10,  0,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(0, 1, 12, 32'hE,        0,        0, 0,   0,  0, 32'h0,         32'hE,         0,        0));
    tv.push_back(mk(0, 0, 0,  0,            32'h800,  1, 9,   0,  0, 32'h0,         32'hE,         0,        0));
    tv.push_back(mk(0, 1, 12, 32'hF,        0,        0, 0,   0,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(0, 1, 14, 32'h1234,     0,        0, 0,   0,  0, 32'h0,         32'hF,         32'h1234, 0));
    tv.push_back(mk(0, 1, 14, 32'h0,        0,        0, 0,   0,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(0, 1, 5,  32'hDEAD,     0,        0, 0,   0,  0, 32'h0,         32'hF,         0,        0));
    tv.push_back(mk(1, 0, 5,  0,            0,        0, 0,   0,  0, 32'h0,         32'hF,         0,        0));

    #22 rst_n = 1'b1;
    #1;
    check("reset status", bus.status, 32'hF);
    check("reset exc_addr", bus.exc_addr, 32'h0);
    check("reset depth", 32'(bus.depth), 32'h0);
    check("reset rdata", bus.rdata, 32'h0);

    for (int i = 0; i < tv.size(); i++) apply(tv[i], i);

    // Interrupt through the synchroniser: visible two edges after irq rises
    do_mtc0(12, 32'h10F);
    @(negedge clk);
    bus.irq = 6'b000001; bus.pc = 32'h900;
    #1 check("irq sync0 take", 32'(bus.exc_take), 32'h0);
    @(negedge clk); #1 check("irq sync1 take", 32'(bus.exc_take), 32'h0);
    @(negedge clk); #1 check("irq sync2 take", 32'(bus.exc_take), 32'h1);
    @(posedge clk); #1;
    check("irq status", bus.status, 32'h10E);
    check("irq epc", bus.exc_addr, 32'h900);
    check("irq depth", 32'(bus.depth), 32'h1);
    read_chk("irq cause", 13, 32'h100);
    bus.irq = '0;
    repeat (3) @(negedge clk);
    bus.eret = 1;
    @(posedge clk); #1;
    idle();
    check("irq eret status", bus.status, 32'h10F);
    check("irq eret depth", 32'(bus.depth), 32'h0);
    check("irq eret take", 32'(bus.exc_take), 32'h0);
    do_mtc0(12, 32'hF);

`ifdef CP0_TIMER_EN
    // Timer: Count written to 0, Compare 5 -> TI on the fifth edge after
    do_mtc0(12, 32'h800F);
    do_mtc0(11, 32'h5);
    bus.pc = 32'hA00;
    do_mtc0(9, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("timer wait%0d take", k), 32'(bus.exc_take), 32'h0);
      read_chk($sformatf("timer count%0d", k), 9, 32'(k));
    end
    @(posedge clk); #1;
    check("timer fire take", 32'(bus.exc_take), 32'h1);
    read_chk("timer cause TI", 13, 32'h4000_0000);
    @(posedge clk); #1;
    check("timer entry status", bus.status, 32'h800E);
    check("timer entry epc", bus.exc_addr, 32'hA00);
    check("timer entry depth", 32'(bus.depth), 32'h1);
    do_mtc0(11, 32'hFFFF_FFFF);
    read_chk("timer TI cleared", 13, 32'h0);
    @(negedge clk);
    bus.eret = 1;
    @(posedge clk); #1;
    idle();
    check("timer eret status", bus.status, 32'h800F);
    check("timer eret take", 32'(bus.exc_take), 32'h0);
    do_mtc0(12, 32'hF);
`else
    do_mtc0(11, 32'h5);
    read_chk("no timer compare", 11, 32'h0);
    read_chk("no timer count", 9, 32'h0);
`endif

    // Reset while inside a handler discards the stack
    @(negedge clk);
    bus.exception = 1; bus.cause = 5'd8; bus.pc = 32'h40;
    @(posedge clk); #1;
    idle();
    check("pre-reset depth", 32'(bus.depth), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset depth", 32'(bus.depth), 32'h0);
    check("mid-reset status", bus.status, 32'hF);
    check("mid-reset epc", bus.exc_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.eret = 1;
    @(posedge clk); #1;
    idle();
    check("post-reset eret depth", 32'(bus.depth), 32'h0);
    check("post-reset eret status", bus.status, 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
